// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- bundle of every non-clock signal of pipe_ctrl.
//   upstream   : in_valid, in_data, in_ready
//   downstream : out_valid, out_data, out_ready
//   stage bus  : st_valid, st_data (registers out), st_result, st_busy, kill (stage logic in)
//   status     : occ, stall_cnt, retire_cnt
// modport slave  : the pipeline controller itself
// modport master : the surrounding datapath / environment
interface pipe_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int W      = 32
);
  localparam int OCC_W = $clog2(NSTAGE + 1);

  logic                  in_valid;
  logic [W-1:0]          in_data;
  logic                  in_ready;
  logic [NSTAGE-1:0]     st_valid;
  logic [NSTAGE*W-1:0]   st_data;
  logic [NSTAGE*W-1:0]   st_result;
  logic [NSTAGE-1:0]     st_busy;
  logic [NSTAGE-1:0]     kill;
  logic                  out_valid;
  logic [W-1:0]          out_data;
  logic                  out_ready;
  logic [OCC_W-1:0]      occ;
  logic [31:0]           stall_cnt;
  logic [31:0]           retire_cnt;

  modport slave (
    input  in_valid, in_data, st_result, st_busy, kill, out_ready,
    output in_ready, st_valid, st_data, out_valid, out_data, occ, stall_cnt, retire_cnt
  );

  modport master (
    output in_valid, in_data, st_result, st_busy, kill, out_ready,
    input  in_ready, st_valid, st_data, out_valid, out_data, occ, stall_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- valid/ready controller for an NSTAGE-deep register pipeline.
// Each stage register holds a payload; the external stage logic computes
// st_result from st_data, and stage i's result loads stage i+1 when stage i
// advances. Stages can stall (st_busy) or be flushed (kill). Ready is
// propagated combinationally from out_ready back to in_ready, so a full pipe
// accepts and retires in the same cycle.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   bus         : pipe_ctrl_if.slave (handshakes, stage bus, status counters)
module pipe_ctrl #(
  parameter int NSTAGE = 5,
  parameter int W      = 32
) (
  input logic         clk,
  input logic         resetn,
  pipe_ctrl_if.slave  bus
);
  localparam int OCC_W = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0] vld_q;
  logic [W-1:0]      data_q [NSTAGE];
  logic [31:0]       stall_cnt_q;
  logic [31:0]       retire_cnt_q;

  logic [NSTAGE-1:0] adv;
  logic              in_ready_c;
  logic              out_valid_c;
  logic [OCC_W-1:0]  occ_c;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Ready chain: walk from the output back to stage 0. A stage has room when
  // its successor is empty, leaving this cycle, or being flushed.
  always_comb begin : adv_chain
    logic [NSTAGE-1:0] f;
    logic [NSTAGE-1:0] a;
    f = '0;
    a = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (i == NSTAGE - 1) f[i] = bus.out_ready;
      else                 f[i] = !vld_q[i+1] | a[i+1] | bus.kill[i+1];
      a[i] = vld_q[i] & !bus.st_busy[i] & !bus.kill[i] & f[i];
    end
    adv = a;
  end

  assign in_ready_c  = !vld_q[0] | adv[0] | bus.kill[0];
  assign out_valid_c = vld_q[NSTAGE-1] & !bus.st_busy[NSTAGE-1] & !bus.kill[NSTAGE-1];

  // Reset forces the idle handshake values even before the first reset edge.
  assign bus.in_ready  = !resetn | in_ready_c;
  assign bus.out_valid = resetn & out_valid_c;
  assign bus.out_data  = bus.st_result[(NSTAGE-1)*W +: W];
  assign bus.st_valid  = vld_q;

  always_comb begin
    bus.st_data = '0;
    for (int i = 0; i < NSTAGE; i++) bus.st_data[i*W +: W] = data_q[i];
  end

  always_comb begin
    occ_c = '0;
    for (int i = 0; i < NSTAGE; i++) occ_c = occ_c + OCC_W'(vld_q[i]);
  end
  assign bus.occ = occ_c;

  // Stage registers: kill beats load beats bubble beats hold. A kill on
  // stage i also discards whatever stage i-1 was pushing into it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int i = 0; i < NSTAGE; i++) data_q[i] <= '0;
    end else begin
      if (bus.kill[0]) begin
        vld_q[0] <= 1'b0;
      end else if (bus.in_valid && in_ready_c) begin
        vld_q[0]  <= 1'b1;
        data_q[0] <= bus.in_data;
      end else if (adv[0]) begin
        vld_q[0] <= 1'b0;
      end
      for (int i = 1; i < NSTAGE; i++) begin
        if (bus.kill[i]) begin
          vld_q[i] <= 1'b0;
        end else if (adv[i-1]) begin
          vld_q[i]  <= 1'b1;
          data_q[i] <= bus.st_result[(i-1)*W +: W];
        end else if (adv[i]) begin
          vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // Status counters: stalls saturate, retires wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (bus.in_valid && !in_ready_c) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (out_valid_c && bus.out_ready) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- bench for pipe_ctrl (NSTAGE=5, W=32). The stage logic is
// st_result = st_data + 1. A per-cycle reference model of stage occupancy and
// counters checks every output; scoreboards check end-to-end payload order.
module tb_pipe_ctrl;
  localparam int N = 5;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NSTAGE(N), .W(W)) ifc ();
  pipe_ctrl #(.NSTAGE(N), .W(W)) dut (.clk(clk), .resetn(resetn), .bus(ifc));

  always_comb begin
    ifc.st_result = '0;
    for (int i = 0; i < N; i++) ifc.st_result[i*W +: W] = ifc.st_data[i*W +: W] + 32'd1;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [N-1:0] mvld = '0;
  logic [W-1:0] mdat [N] = '{default: '0};
  logic [31:0]  mstall = '0;
  logic [31:0]  mret = '0;

  logic [W-1:0] accq[$];
  logic [W-1:0] retq[$];
  int cyc = 0;
  int first_hs = -1;
  int first_ov = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [N-1:0] mov;
    logic room, acc, ov;
    int cnt;
    #1;
    acc = 1'b1;
    ov  = 1'b0;
    mov = '0;
    if (resetn) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i == N - 1) room = ifc.out_ready;
        else            room = !mvld[i+1] || mov[i+1] || ifc.kill[i+1];
        mov[i] = mvld[i] && !ifc.st_busy[i] && !ifc.kill[i] && room;
      end
      acc = !mvld[0] || mov[0] || ifc.kill[0];
      ov  = mvld[N-1] && !ifc.st_busy[N-1] && !ifc.kill[N-1];
    end
    cnt = $countones(mvld);
    chk("in_ready", ifc.in_ready, acc);
    chk("out_valid", ifc.out_valid, ov);
    if (ov) chk("out_data", ifc.out_data, mdat[N-1] + 32'd1);
    chk("st_valid", ifc.st_valid, mvld);
    chk("occ", ifc.occ, cnt);
    chk("stall_cnt", ifc.stall_cnt, mstall);
    chk("retire_cnt", ifc.retire_cnt, mret);
    for (int i = 0; i < N; i++)
      if (mvld[i]) chk($sformatf("st_data%0d", i), ifc.st_data[i*W +: W], mdat[i]);

    if (resetn && ifc.in_valid && acc && !ifc.kill[0]) begin
      accq.push_back(ifc.in_data);
      if (first_hs < 0) first_hs = cyc;
    end
    if (resetn && ifc.out_valid && ifc.out_ready) begin
      retq.push_back(ifc.out_data);
      if (first_ov < 0) first_ov = cyc;
    end

    if (!resetn) begin
      mvld = '0;
      for (int i = 0; i < N; i++) mdat[i] = '0;
      mstall = '0;
      mret = '0;
    end else begin
      if (ifc.in_valid && !acc && mstall != 32'hFFFF_FFFF) mstall = mstall + 32'd1;
      if (ov && ifc.out_ready) mret = mret + 32'd1;
      for (int i = N - 1; i >= 0; i--) begin
        if (ifc.kill[i]) begin
          mvld[i] = 1'b0;
        end else if (i == 0 && ifc.in_valid && acc) begin
          mvld[0] = 1'b1;
          mdat[0] = ifc.in_data;
        end else if (i > 0 && mov[(i > 0) ? i - 1 : 0]) begin
          mvld[i] = 1'b1;
          mdat[i] = mdat[i-1] + 32'd1;
        end else if (mov[i]) begin
          mvld[i] = 1'b0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic iv, input logic [W-1:0] d, input logic ordy,
                     input logic [N-1:0] b, input logic [N-1:0] k);
    ifc.in_valid  = iv;
    ifc.in_data   = d;
    ifc.out_ready = ordy;
    ifc.st_busy   = b;
    ifc.kill      = k;
    step();
  endtask

  // Every accepted payload must retire exactly once, in order, after five +1 steps.
  task automatic sb_check(input string nm);
    chk({nm, "_count"}, retq.size(), accq.size());
    for (int i = 0; i < retq.size() && i < accq.size(); i++)
      chk({nm, "_data"}, retq[i], accq[i] + 32'd5);
    accq.delete();
    retq.delete();
  endtask

  initial begin
    logic [W-1:0] nxt;
    logic [31:0] s0;
    logic [N*W-1:0] dsnap;
    logic [W-1:0] victim;
    logic found;
    logic [N-1:0] rb, rk;

    ifc.in_valid = 0; ifc.in_data = '0; ifc.out_ready = 0; ifc.st_busy = '0; ifc.kill = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset with garbage on the inputs
    for (int k = 0; k < 3; k++) drv(1'b1, $urandom, 1'b1, N'($urandom), N'($urandom));
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_st_data_zero", (ifc.st_data == '0), 1);
    resetn = 1'b1;
    accq.delete(); retq.delete();

    // Streaming 0x10..0x17
    first_hs = -1; first_ov = -1;
    for (int k = 0; k < 8; k++) drv(1'b1, 32'h10 + k, 1'b1, '0, '0);
    for (int k = 0; k < 8; k++) drv(1'b0, $urandom, 1'b1, '0, '0);
    chk("stream_latency", first_ov - first_hs, 5);
    chk("stream_first", (retq.size() > 0) ? retq[0] : 32'hDEAD, 32'h15);
    chk("stream_retire", ifc.retire_cnt, 8);
    sb_check("stream");

    // Backpressure
    nxt = 32'h100;
    for (int k = 0; k < 5; k++) begin drv(1'b1, nxt, 1'b0, '0, '0); nxt++; end
    s0 = ifc.stall_cnt;
    dsnap = ifc.st_data;
    for (int k = 0; k < 3; k++) drv(1'b1, nxt, 1'b0, '0, '0);
    chk("bp_occ", ifc.occ, 5);
    chk("bp_in_ready", ifc.in_ready, 0);
    chk("bp_stall_delta", ifc.stall_cnt - s0, 3);
    chk("bp_hold", (ifc.st_data == dsnap), 1);
    for (int k = 0; k < 6; k++) begin drv(1'b1, nxt, 1'b1, '0, '0); nxt++; end
    for (int k = 0; k < 10; k++) drv(1'b0, $urandom, 1'b1, '0, '0);
    sb_check("bp");

    // Busy stage 2 for two cycles in a full stream
    nxt = 32'h200;
    for (int k = 0; k < 6; k++) begin drv(1'b1, nxt, 1'b1, '0, '0); nxt++; end
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, nxt, 1'b1, 5'b00100, '0);
      chk("busy_bubble3", ifc.st_valid[3], 0);
    end
    for (int k = 0; k < 3; k++) begin drv(1'b1, nxt, 1'b1, '0, '0); nxt++; end
    for (int k = 0; k < 10; k++) drv(1'b0, $urandom, 1'b1, '0, '0);
    sb_check("busy");

    // Flush lower three stages of a full pipe with an input offered
    nxt = 32'h300;
    for (int k = 0; k < 5; k++) begin drv(1'b1, nxt, 1'b0, '0, '0); nxt++; end
    accq.delete(); retq.delete();
    drv(1'b1, nxt, 1'b0, '0, 5'b00111);
    chk("flush_valid", ifc.st_valid, 5'b11000);
    chk("flush_occ", ifc.occ, 2);
    for (int k = 0; k < 8; k++) drv(1'b0, $urandom, 1'b1, '0, '0);
    chk("flush_retired", retq.size(), 2);
    accq.delete(); retq.delete();

    // Kill stage 3 while stage 2 advances
    nxt = 32'h400;
    for (int k = 0; k < 6; k++) begin drv(1'b1, nxt, 1'b1, '0, '0); nxt++; end
    victim = mdat[2] + 32'd3;
    drv(1'b1, nxt, 1'b1, '0, 5'b01000);
    nxt++;
    chk("kva_v3", ifc.st_valid[3], 0);
    for (int k = 0; k < 10; k++) drv(1'b0, $urandom, 1'b1, '0, '0);
    found = 1'b0;
    foreach (retq[i]) if (retq[i] == victim) found = 1'b1;
    chk("kva_lost", found, 0);
    chk("kva_count", retq.size(), accq.size() - 2);
    accq.delete(); retq.delete();

    // Stall counter saturation (preload near the top)
    for (int k = 0; k < 5; k++) drv(1'b1, $urandom, 1'b0, '0, '0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    mstall = 32'hFFFF_FFFD;
    for (int k = 0; k < 4; k++) drv(1'b1, $urandom, 1'b0, '0, '0);
    chk("sat_stall", ifc.stall_cnt, 32'hFFFF_FFFF);

    // Reset mid-stream with stages 0..3 valid
    for (int k = 0; k < 6; k++) drv(1'b0, $urandom, 1'b1, '0, '0);
    for (int k = 0; k < 4; k++) drv(1'b1, $urandom, 1'b0, '0, '0);
    chk("mid_occ4", ifc.occ, 4);
    resetn = 1'b0;
    drv(1'b1, $urandom, 1'b1, '0, '0);
    resetn = 1'b1;
    ifc.in_valid = 1'b0;
    #1;
    chk("mid_st_valid", ifc.st_valid, 0);
    chk("mid_occ", ifc.occ, 0);
    chk("mid_in_ready", ifc.in_ready, 1);
    chk("mid_out_valid", ifc.out_valid, 0);
    chk("mid_stall", ifc.stall_cnt, 0);
    chk("mid_retire", ifc.retire_cnt, 0);
    @(negedge clk);
    accq.delete(); retq.delete();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        rb[i] = ($urandom_range(0, 7) == 0);
        rk[i] = ($urandom_range(0, 31) == 0);
      end
      resetn = ($urandom_range(0, 199) != 0);
      drv($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, rb, rk);
    end
    resetn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
